lsu: RTL and testbench
======================

// Module: lsu
// PURPOSE
//  Load/store unit downstream of exu. Latches one memory request per instruction and runs a
//  valid/ready transaction on the data-memory bus. Returns aligned load data (lw/lbu) to rf
//  writeback with a one-cycle wb_valid pulse. Holds busy high so ifu/exu stall while a
//  transaction is outstanding.
// PARAMETERS
//  ADDR_W          24   word-address width (byte address [ADDR_W+1:2])
//  TIMEOUT_CYCLES  255  bus wait limit in cycles; used only when LSU_TIMEOUT_EN is defined
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       asynchronous, active-low reset
//  ex_valid       in   1       exu presents an instruction this cycle
//  ex_ready       out  1       lsu can accept; equals (state==IDLE)
//  mem_ren        in   1       load (lw or lbu)
//  mem_wen        in   1       store (sw or sb)
//  is_lbu         in   1       load is lbu; else lw
//  mem_addr       in   ADDR_W  word address
//  sel            in   2       byte offset within word
//  mem_mask       in   4       store byte-enable
//  mem_wdata      in   32      store data, already lane-shifted
//  rd             in   5       load destination register
//  bus_req_valid  out  1       request valid
//  bus_req_ready  in   1       memory accepts request
//  bus_req_we     out  1       1 = write
//  bus_req_addr   out  ADDR_W  request word address
//  bus_req_mask   out  4       byte-enable; 4'b1111 for loads
//  bus_req_wdata  out  32      write data
//  bus_rsp_valid  in   1       response valid
//  bus_rsp_ready  out  1       lsu accepts response; equals (state==RSP)
//  bus_rsp_rdata  in   32      read data
//  bus_rsp_err    in   1       bus error with response
//  wb_valid       out  1       one-cycle completion pulse
//  wb_wen         out  1       write rf (successful load only)
//  wb_rd          out  5       destination register
//  wb_data        out  32      aligned load data
//  wb_err         out  1       transaction failed (bus error or timeout)
//  busy           out  1       state != IDLE
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE; all outputs 0 except ex_ready=1; latched regs cleared.
//    Reset mid-transaction drops it; no wb_valid is produced for it.
//  - FSM IDLE -> REQ -> RSP -> DONE -> IDLE.
//  - IDLE: on ex_valid & (mem_ren|mem_wen), latch the request and go to REQ. ex_valid with
//    neither set is consumed with no action. If both are set, the store wins.
//  - REQ: bus_req_valid=1; bus_req_* held stable from the latch. On bus_req_ready, go to RSP.
//  - RSP: bus_rsp_ready=1. On bus_rsp_valid, register rdata/err and go to DONE.
//  - DONE: wb_valid=1 for exactly 1 cycle, then IDLE.
//      - wb_wen = load & !err.
//      - wb_rd = latched rd.
//      - wb_err = err.
//  - Load data: lw -> rdata unchanged; lbu -> {24'b0, rdata[8*sel+7 -: 8]} using latched sel.
//    Store or error -> wb_data=0.
//  - Minimum latency, accept at cycle T with ready/rsp at first opportunity:
//      - REQ at T+1.
//      - RSP at T+2.
//      - wb_valid at T+3.
//    Throughput is one op per 4 cycles.
//  - A store with mem_mask=0 is still issued on the bus.
//  - Inputs are ignored while state!=IDLE; exu holds its instruction because ex_ready=0.
// CONFIGURATION
//  LSU_TIMEOUT_EN defined:
//    - A counter clears on entry to REQ and increments each cycle in REQ or RSP.
//    - When count==TIMEOUT_CYCLES-1 and no handshake completes that cycle, go to DONE with
//      wb_err=1, wb_wen=0.
//    - If a handshake completes in the expiry cycle, the handshake wins.
//  LSU_TIMEOUT_EN undefined: no counter logic; lsu waits indefinitely; wb_err only from
//  bus_rsp_err.
// TESTING
//  1. lw, addr=0x000010, mem word 0xDEADBEEF, ready/rsp immediate -> wb_valid at T+3,
//     wb_wen=1, wb_data=0xDEADBEEF.
//  2. lbu sel=2 on word 0x11223344 -> wb_data=0x00000022; sel=3 -> 0x00000011.
//  3. sb mask=4'b0100, wdata=0x00AB0000 -> bus_req_we=1, mask=0100; wb_valid with wb_wen=0.
//  4. bus_req_ready low 5 cycles, rsp delayed 3 -> bus_req_* stable; busy=1 throughout;
//     exactly one wb_valid.
//  5. bus_rsp_err=1 on lw -> wb_err=1, wb_wen=0; reset asserted in RSP -> outputs 0,
//     ex_ready=1, no wb_valid.
//  6. LSU_TIMEOUT_EN, TIMEOUT_CYCLES=8, ready never asserted -> wb_err pulse 8 cycles after
//     REQ entry; without the macro busy stays 1.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: one outstanding valid/ready data-memory transaction, lw/lbu writeback.
// Optional bus wait limit enabled by defining LSU_TIMEOUT_EN.
module lsu #(
  parameter int ADDR_W         = 24,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic              is_lbu,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        sel,
  input  logic [3:0]        mem_mask,
  input  logic [31:0]       mem_wdata,
  input  logic [4:0]        rd,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_req_we,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic [3:0]        bus_req_mask,
  output logic [31:0]       bus_req_wdata,
  input  logic              bus_rsp_valid,
  output logic              bus_rsp_ready,
  input  logic [31:0]       bus_rsp_rdata,
  input  logic              bus_rsp_err,
  output logic              wb_valid,
  output logic              wb_wen,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              wb_err,
  output logic              busy
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_DONE} state_t;

  state_t            r_state;
  logic              r_we, r_lbu, r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_sel;
  logic [3:0]        r_mask;
  logic [31:0]       r_wdata, r_data;
  logic [4:0]        r_rd;

  logic        w_req_hs, w_rsp_hs, w_expire, w_accept;
  logic [31:0] w_shift, w_load_data;

  assign w_accept    = (r_state == S_IDLE) && ex_valid && (mem_ren || mem_wen);
  assign w_req_hs    = (r_state == S_REQ) && bus_req_ready;
  assign w_rsp_hs    = (r_state == S_RSP) && bus_rsp_valid;
  assign w_shift     = bus_rsp_rdata >> {r_sel, 3'b000};
  assign w_load_data = r_lbu ? {24'b0, w_shift[7:0]} : bus_rsp_rdata;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] r_tcnt;

  // A handshake in the expiry cycle takes priority over the timeout.
  assign w_expire = ((r_state == S_REQ) || (r_state == S_RSP)) && !w_req_hs && !w_rsp_hs &&
                    (r_tcnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                            r_tcnt <= '0;
    else if (w_accept)                                   r_tcnt <= '0;
    else if ((r_state == S_REQ) || (r_state == S_RSP))   r_tcnt <= r_tcnt + 1'b1;
  end
`else
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_lbu   <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_sel   <= '0;
      r_mask  <= '0;
      r_wdata <= '0;
      r_data  <= '0;
      r_rd    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_state <= S_REQ;
          r_we    <= mem_wen;
          r_lbu   <= is_lbu;
          r_addr  <= mem_addr;
          r_sel   <= sel;
          r_mask  <= mem_wen ? mem_mask : 4'b1111;
          r_wdata <= mem_wdata;
          r_rd    <= rd;
        end
        S_REQ: begin
          if (w_req_hs) r_state <= S_RSP;
          else if (w_expire) begin
            r_state <= S_DONE;
            r_err   <= 1'b1;
            r_data  <= '0;
          end
        end
        S_RSP: begin
          if (w_rsp_hs) begin
            r_state <= S_DONE;
            r_err   <= bus_rsp_err;
            r_data  <= (r_we || bus_rsp_err) ? 32'b0 : w_load_data;
          end else if (w_expire) begin
            r_state <= S_DONE;
            r_err   <= 1'b1;
            r_data  <= '0;
          end
        end
        default: begin
          // Clear so writeback fields read 0 outside the completion pulse.
          r_state <= S_IDLE;
          r_err   <= 1'b0;
          r_data  <= '0;
        end
      endcase
    end
  end

  assign ex_ready      = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign bus_req_valid = (r_state == S_REQ);
  assign bus_rsp_ready = (r_state == S_RSP);
  assign bus_req_we    = r_we;
  assign bus_req_addr  = r_addr;
  assign bus_req_mask  = r_mask;
  assign bus_req_wdata = r_wdata;
  assign wb_valid      = (r_state == S_DONE);
  assign wb_wen        = wb_valid && !r_we && !r_err;
  assign wb_err        = wb_valid && r_err;
  assign wb_rd         = wb_valid ? r_rd : 5'd0;
  assign wb_data       = r_data;
endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: expected writebacks queued at issue, compared on wb_valid.
module tb_lsu;
  localparam int AW = 24;

  typedef struct packed {
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
  } wb_t;

  logic          clk = 0, rst = 0;
  logic          ex_valid = 0, mem_ren = 0, mem_wen = 0, is_lbu = 0;
  logic [AW-1:0] mem_addr = '0;
  logic [1:0]    sel = '0;
  logic [3:0]    mem_mask = '0;
  logic [31:0]   mem_wdata = '0;
  logic [4:0]    rd = '0;
  logic          bus_req_ready = 0, bus_rsp_valid = 0, bus_rsp_err = 0;
  logic [31:0]   bus_rsp_rdata = '0;
  logic          ex_ready, bus_req_valid, bus_req_we, bus_rsp_ready;
  logic [AW-1:0] bus_req_addr;
  logic [3:0]    bus_req_mask;
  logic [31:0]   bus_req_wdata, wb_data;
  logic          wb_valid, wb_wen, wb_err, busy;
  logic [4:0]    wb_rd;

  int  n_chk = 0, n_err = 0;
  wb_t sb[$];

  lsu #(.ADDR_W(AW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .is_lbu(is_lbu), .mem_addr(mem_addr),
    .sel(sel), .mem_mask(mem_mask), .mem_wdata(mem_wdata), .rd(rd),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_we(bus_req_we),
    .bus_req_addr(bus_req_addr), .bus_req_mask(bus_req_mask), .bus_req_wdata(bus_req_wdata),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_ready(bus_rsp_ready),
    .bus_rsp_rdata(bus_rsp_rdata), .bus_rsp_err(bus_rsp_err),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_err(wb_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Writeback monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && wb_valid) begin
      if (sb.size() == 0) chk("wb_spurious", {31'b0, wb_valid}, 32'd0);
      else begin
        wb_t e;
        e = sb.pop_front();
        chk("wb_wen",  {31'b0, wb_wen}, {31'b0, e.wen});
        chk("wb_rd",   {27'b0, wb_rd},  {27'b0, e.rd});
        chk("wb_data", wb_data,         e.data);
        chk("wb_err",  {31'b0, wb_err}, {31'b0, e.err});
      end
    end
  end

  function automatic wb_t model(input logic ren, input logic wen, input logic lbu,
                                input logic [1:0] s, input logic [4:0] r,
                                input logic [31:0] rdata, input logic err);
    wb_t   e;
    logic  ld;
    ld     = ren && !wen;
    e.wen  = ld && !err;
    e.rd   = r;
    e.err  = err;
    if (!ld || err) e.data = 32'd0;
    else if (lbu)   e.data = (rdata >> (8 * s)) & 32'hFF;
    else            e.data = rdata;
    return e;
  endfunction

  task automatic drive_ex(input logic ren, input logic wen, input logic lbu,
                          input logic [AW-1:0] a, input logic [1:0] s, input logic [3:0] m,
                          input logic [31:0] wd, input logic [4:0] r);
    ex_valid = 1; mem_ren = ren; mem_wen = wen; is_lbu = lbu;
    mem_addr = a; sel = s; mem_mask = m; mem_wdata = wd; rd = r;
  endtask

  task automatic check_req(input logic wen, input logic ren, input logic [AW-1:0] a,
                           input logic [3:0] m, input logic [31:0] wd);
    chk("req_valid", {31'b0, bus_req_valid}, 32'd1);
    chk("req_we",    {31'b0, bus_req_we},    {31'b0, wen});
    chk("req_addr",  {8'b0, bus_req_addr},   {8'b0, a});
    chk("req_mask",  {28'b0, bus_req_mask},  {28'b0, (wen || !ren) ? m : 4'hF});
    chk("req_wdata", bus_req_wdata,          wd);
    chk("busy",      {31'b0, busy},          32'd1);
  endtask

  // Full transaction with programmable bus stalls; junk ex traffic during stalls must be ignored.
  task automatic op(input logic ren, input logic wen, input logic lbu,
                    input logic [AW-1:0] a, input logic [1:0] s, input logic [3:0] m,
                    input logic [31:0] wd, input logic [4:0] r,
                    input logic [31:0] rdata, input logic err,
                    input int req_dly, input int rsp_dly);
    @(negedge clk);
    drive_ex(ren, wen, lbu, a, s, m, wd, r);
    @(posedge clk); #1;
    sb.push_back(model(ren, wen, lbu, s, r, rdata, err));
    ex_valid = 0;
    for (int i = 0; i < req_dly; i++) begin
      drive_ex(1'b1, 1'b0, 1'b0, ~a, ~s, 4'h3, ~wd, ~r);
      check_req(wen, ren, a, m, wd);
      chk("ex_ready_busy", {31'b0, ex_ready}, 32'd0);
      @(posedge clk); #1;
    end
    ex_valid = 0;
    check_req(wen, ren, a, m, wd);
    bus_req_ready = 1;
    @(posedge clk); #1;
    bus_req_ready = 0;
    for (int i = 0; i < rsp_dly; i++) begin
      chk("rsp_ready", {31'b0, bus_rsp_ready}, 32'd1);
      chk("req_valid_off", {31'b0, bus_req_valid}, 32'd0);
      @(posedge clk); #1;
    end
    chk("rsp_ready", {31'b0, bus_rsp_ready}, 32'd1);
    bus_rsp_valid = 1; bus_rsp_rdata = rdata; bus_rsp_err = err;
    @(posedge clk); #1;
    bus_rsp_valid = 0; bus_rsp_rdata = '0; bus_rsp_err = 0;
    chk("wb_valid_lat", {31'b0, wb_valid}, 32'd1);
    @(posedge clk); #1;
    chk("wb_pulse", {31'b0, wb_valid}, 32'd0);
    chk("ex_ready_ret", {31'b0, ex_ready}, 32'd1);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_ex_ready", {31'b0, ex_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_req_valid", {31'b0, bus_req_valid}, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1;

    // lw, lbu lanes, stores (including mask 0 and ren+wen -> store)
    op(1, 0, 0, 24'h000010, 2'd0, 4'h0, 32'h0, 5'd3, 32'hDEADBEEF, 0, 0, 0);
    op(1, 0, 1, 24'h000020, 2'd2, 4'h0, 32'h0, 5'd7, 32'h11223344, 0, 0, 0);
    op(1, 0, 1, 24'h000020, 2'd3, 4'h0, 32'h0, 5'd8, 32'h11223344, 0, 0, 0);
    op(1, 0, 1, 24'h000024, 2'd0, 4'h0, 32'h0, 5'd9, 32'hA5A5A5F0, 0, 0, 0);
    op(0, 1, 0, 24'h000030, 2'd2, 4'b0100, 32'h00AB0000, 5'd1, 32'hFFFFFFFF, 0, 0, 0);
    op(0, 1, 0, 24'hFFFFFF, 2'd0, 4'b0000, 32'h12345678, 5'd2, 32'h0, 0, 1, 0);
    op(1, 1, 0, 24'h000040, 2'd0, 4'b0011, 32'h0000BEEF, 5'd4, 32'hCAFEF00D, 0, 0, 0);

    // No-op ex_valid is consumed without starting a transaction
    @(negedge clk);
    drive_ex(0, 0, 0, 24'h55, 2'd0, 4'hF, 32'h0, 5'd5);
    @(posedge clk); #1;
    ex_valid = 0;
    chk("noop_busy", {31'b0, busy}, 32'd0);

    // Stalled bus, then bus error
    op(1, 0, 0, 24'h123456, 2'd1, 4'h0, 32'h0, 5'd10, 32'h0BADF00D, 0, 5, 3);
    op(1, 0, 0, 24'h000050, 2'd0, 4'h0, 32'h0, 5'd11, 32'h77777777, 1, 0, 0);
    op(1, 0, 1, 24'h000054, 2'd1, 4'h0, 32'h0, 5'd12, 32'h77777777, 1, 2, 1);

    // Reset while waiting for the response: transaction dropped
    @(negedge clk);
    drive_ex(1, 0, 0, 24'h000060, 2'd0, 4'h0, 32'h0, 5'd13);
    @(posedge clk); #1;
    ex_valid = 0; bus_req_ready = 1;
    @(posedge clk); #1;
    bus_req_ready = 0;
    chk("mid_rsp_ready", {31'b0, bus_rsp_ready}, 32'd1);
    rst = 0; #1;
    chk("mid_rst_ex_ready", {31'b0, ex_ready}, 32'd1);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_rsp_ready", {31'b0, bus_rsp_ready}, 32'd0);
    chk("mid_rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("mid_rst_addr", {8'b0, bus_req_addr}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {31'b0, busy}, 32'd0);

    // Memory never accepts the request
    @(negedge clk);
    drive_ex(1, 0, 0, 24'h000070, 2'd0, 4'h0, 32'h0, 5'd14);
    @(posedge clk); #1;
    ex_valid = 0;
`ifdef LSU_TIMEOUT_EN
    begin
      int cyc;
      bit seen;
      sb.push_back(model(1, 0, 0, 2'd0, 5'd14, 32'h0, 1'b1));
      cyc = 0; seen = 0;
      while (!seen && cyc < 40) begin
        @(posedge clk); #1;
        cyc++;
        if (wb_valid) seen = 1;
      end
      chk("timeout_seen", {31'b0, seen}, 32'd1);
      chk("timeout_cycles", cyc, 32'd8);
      @(posedge clk); #1;
    end
`else
    for (int i = 0; i < 20; i++) begin
      chk("hang_busy", {31'b0, busy}, 32'd1);
      @(posedge clk); #1;
    end
    sb.push_back(model(1, 0, 0, 2'd0, 5'd14, 32'h31415926, 1'b0));
    bus_req_ready = 1;
    @(posedge clk); #1;
    bus_req_ready = 0;
    bus_rsp_valid = 1; bus_rsp_rdata = 32'h31415926;
    @(posedge clk); #1;
    bus_rsp_valid = 0; bus_rsp_rdata = '0;
    chk("drain_wb_valid", {31'b0, wb_valid}, 32'd1);
    @(posedge clk); #1;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
